// File: rtl/fx2_slfifo_writer.sv
// fx2_slfifo_writer
// Drains a normal-mode dual-clock FIFO (read side) into the Cypress FX2 slave
// FIFO IN endpoint at up to one 16-bit word per ifclk. A 2-entry skid buffer
// absorbs the word already requested when the FX2 stalls. A flush request
// commits any partial packet with PKTEND. A running count of the words
// accepted by the FX2 is kept. All logic is in the ifclk domain.
module fx2_slfifo_writer #(
   parameter int unsigned PKT_WORDS = 256,
   parameter logic [1:0]  EP_ADR    = 2'b10,
   parameter int unsigned CNT_W     = 32
) (
   input  logic             ifclk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             flush,
   input  logic             rdempty,
   input  logic [15:0]      q,
   output logic             rdreq,
   input  logic             fx2_full_n,
   output logic [15:0]      fx2_fd,
   output logic             fx2_slwr_n,
   output logic             fx2_pktend_n,
   output logic [1:0]       fx2_fifoadr,
   output logic             fx2_sloe_n,
   output logic             flush_done,
   output logic [CNT_W-1:0] words_sent
);

   localparam int PKT_W = $clog2(PKT_WORDS);

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_COMMIT = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic               flush_pend_q, flush_pend_d;
   logic [15:0]        head_q, head_d;
   logic [15:0]        tail_q, tail_d;
   logic [1:0]         occ_q, occ_d;
   logic               inflight_q;
   logic [PKT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
   logic [CNT_W-1:0]   words_q, words_d;

   logic               fire;
   logic               commit_go;
   logic               drain_ok;
   logic [2:0]         level;
   logic [1:0]         wr_idx;

   // Everything written to the FX2 has left the source FIFO, the skid buffer
   // and the read pipeline.
   assign drain_ok = flush_pend_q & rdempty & (occ_q == 2'd0) & ~inflight_q;

   // State register: FSM state and the pending-flush flag.
   always_ff @(posedge ifclk) begin
      // NOTE: sequential state is updated with non-blocking assignments so every
      // register samples the values from before the edge, independent of order.
      if (!reset_n) begin
         state_q      <= ST_RUN;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   // Next-state logic: latch flush requests, commit a partial packet once drained.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the block leaves it unassigned and infers a latch.
      state_d      = state_q;
      flush_pend_d = flush_pend_q;
      unique case (state_q)
         ST_RUN: begin
            if (flush) flush_pend_d = 1'b1;
            if (drain_ok) begin
               if (pkt_cnt_q != '0) state_d      = ST_COMMIT;
               else                 flush_pend_d = 1'b0;
            end
         end
         ST_COMMIT: begin
            if (fx2_full_n) begin
               state_d      = ST_RUN;
               flush_pend_d = 1'b0;
            end
         end
      endcase
   end

   // Output logic: write strobe, read request and PKTEND. Outputs are held at
   // their idle values while reset_n is low so nothing is written or requested
   // during the reset cycle.
   always_comb begin
      fire         = reset_n & (occ_q != 2'd0) & fx2_full_n & (state_q != ST_COMMIT);
      level        = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, fire};
      rdreq        = reset_n & enable & ~rdempty & (state_q == ST_RUN) & (level < 3'd2);
      commit_go    = reset_n & (state_q == ST_COMMIT) & fx2_full_n;
      fx2_slwr_n   = ~fire;
      fx2_pktend_n = ~commit_go;
      flush_done   = commit_go
                   | (reset_n & (state_q == ST_RUN) & drain_ok & (pkt_cnt_q == '0));
      fx2_fd       = head_q;
      fx2_fifoadr  = EP_ADR;
      fx2_sloe_n   = 1'b1;
      words_sent   = words_q;
   end

   // Skid buffer and counter next-state: pop the head on a write, append the
   // word returned for last cycle's read behind whatever remains.
   always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      occ_d     = level[1:0];
      wr_idx    = occ_q - {1'b0, fire};
      pkt_cnt_d = pkt_cnt_q;
      words_d   = words_q;
      if (fire) head_d = tail_q;
      if (inflight_q) begin
         if (wr_idx == 2'd0) head_d = q;
         else                tail_d = q;
      end
      if (fire) begin
         pkt_cnt_d = pkt_cnt_q + PKT_W'(1);
         words_d   = words_q + CNT_W'(1);
      end else if (commit_go) begin
         pkt_cnt_d = '0;
      end
   end

   // Datapath registers: skid buffer, read pipeline flag and counters.
   always_ff @(posedge ifclk) begin
      if (!reset_n) begin
         // NOTE: the two buffer words are reset as well; there are only two and
         // this keeps fx2_fd at zero after reset instead of showing stale data.
         head_q     <= '0;
         tail_q     <= '0;
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         pkt_cnt_q  <= '0;
         words_q    <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         occ_q      <= occ_d;
         inflight_q <= rdreq;
         pkt_cnt_q  <= pkt_cnt_d;
         words_q    <= words_d;
      end
   end

endmodule

// File: doc/fx2_slfifo_writer.md
Name: fx2_slfifo_writer

Overview:
Downstream stage of the 120/48 MHz dual-clock sample FIFO (normal-mode dcfifo, 16-bit).
- Runs entirely in the ifclk (48 MHz, FX2 IFCLK) domain.
- Drains the FIFO read port and writes the words into the Cypress FX2 slave FIFO (IN endpoint) at up to one word per ifclk.
- Commits short packets with PKTEND on a flush request.
- Keeps a running count of transferred words.

Parameters:
PKT_WORDS, 256, words per full USB packet (512-byte EP buffer); power of two, 2..1024
EP_ADR, 2'b10, value driven on fx2_fifoadr (EP6)
CNT_W, 32, width of words_sent

Ports:
ifclk  in  1  clock, FX2 interface clock
reset_n  in  1  synchronous active-low reset, sampled on rising ifclk
enable  in  1  1 = transfer allowed
flush  in  1  one-cycle pulse; commit any partial packet once FIFO and pipeline are empty
rdempty  in  1  source FIFO empty (read side)
q  in  16  source FIFO data; valid the cycle after rdreq
rdreq  out  1  source FIFO read request
fx2_full_n  in  1  FX2 FLAGB, 0 = endpoint full
fx2_fd  out  16  FX2 data bus
fx2_slwr_n  out  1  FX2 write strobe, active low
fx2_pktend_n  out  1  FX2 packet end, active low
fx2_fifoadr  out  2  constant EP_ADR
fx2_sloe_n  out  1  constant 1
flush_done  out  1  one-cycle pulse when a flush completes
words_sent  out  CNT_W  total words accepted by FX2 since reset, wraps

Behaviour:
Reset values (reset_n=0 at a rising edge):
- rdreq=0, fx2_slwr_n=1, fx2_pktend_n=1, fx2_fd=0, flush_done=0, words_sent=0.
- Buffer empty, inflight=0, pkt_cnt=0, FSM=RUN, pending flush cleared.
- Reset mid-transfer discards buffered and inflight words; none of them are written.

Datapath:
- 2-entry skid buffer (FIFO order) with occupancy occ in 0..2.
- inflight = rdreq registered from the previous cycle; q is captured into the buffer the cycle after rdreq.
- Write fire: fire = (occ>0) & fx2_full_n & FSM!=COMMIT. When fire=1:
  - fx2_slwr_n=0 that cycle;
  - fx2_fd = head entry (fx2_fd is combinational from the head register);
  - head is popped.
- fx2_slwr_n=1 whenever fire=0.
- Read request: rdreq = enable & !rdempty & FSM==RUN & (occ + inflight − fire) < 2.
  - Guarantees no overflow.
  - Sustains 1 word/cycle while fx2_full_n=1.
- fx2_full_n falling: writes stop the same cycle and rdreq stops within one cycle. No data loss or duplication; the buffer absorbs the inflight word.
- enable=0: rdreq=0 next evaluation. Buffered and inflight words are still written.

Counters:
- pkt_cnt (log2(PKT_WORDS) bits) increments on each fire and wraps to 0 after PKT_WORDS. A full packet auto-commits in the FX2 with no PKTEND.
- words_sent increments on each fire and wraps modulo 2^CNT_W.

FSM:
- RUN:
  - flush pulse sets flush_pend (a second flush while pending is ignored).
  - If flush_pend & rdempty & occ==0 & inflight==0:
    - pkt_cnt!=0 → COMMIT;
    - else → RUN with flush_done=1 for one cycle, flush_pend cleared.
  - Data arriving after the flush pulse and before the drain condition is met is written normally before the commit.
- COMMIT:
  - rdreq=0, no writes.
  - When fx2_full_n=1: fx2_pktend_n=0 for exactly one cycle, pkt_cnt←0, flush_done=1 the same cycle, flush_pend cleared, → RUN.
  - While fx2_full_n=0: wait in COMMIT.
- fx2_slwr_n and fx2_pktend_n are never low in the same cycle.

Test Plan:
1. Streaming: reset 10 cycles, enable=1, FIFO preloaded with 0x0000..0x01FF, fx2_full_n=1 → 512 consecutive slwr_n=0 cycles, fx2_fd=0,1,…,0x1FF in order, first write 2 cycles after first rdreq, words_sent=512, no pktend.
2. Backpressure: stream as in 1, drop fx2_full_n for 5 cycles at word 100 → no writes during low, exactly one extra read at most, sequence continuous 0..N with no gap or repeat, occ never >2.
3. Flush short packet: write 10 words, flush pulse → after last write one pktend_n=0 cycle, flush_done=1 same cycle, pkt_cnt=0, words_sent=10.
4. Flush on packet boundary: exactly 256 words then flush → no pktend, flush_done pulse one cycle after drain.
5. Flush while full: 3 words, fx2_full_n=0, flush → pktend held off until fx2_full_n=1, then a single pktend_n=0 cycle.
6. Reset mid-stream: reset_n=0 for one cycle with occ=2 → next cycle all outputs at reset values, the discarded words never appear on fx2_fd, words_sent=0.
